// File: rtl/jogo_pkg.sv
// Shared state codes and width helper for the parametrised memory game.
package jogo_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_INICIAL     = 4'd0;
  localparam logic [ST_W-1:0] ST_PREPARA     = 4'd1;
  localparam logic [ST_W-1:0] ST_ESPERA      = 4'd2;
  localparam logic [ST_W-1:0] ST_REGISTRA    = 4'd3;
  localparam logic [ST_W-1:0] ST_COMPARA     = 4'd4;
  localparam logic [ST_W-1:0] ST_PROX_JOGADA = 4'd5;
  localparam logic [ST_W-1:0] ST_PROX_RODADA = 4'd6;
  localparam logic [ST_W-1:0] ST_FIM_ACERTO  = 4'd7;
  localparam logic [ST_W-1:0] ST_FIM_ERRO    = 4'd8;
  localparam logic [ST_W-1:0] ST_FIM_TIMEOUT = 4'd9;

  typedef enum logic [ST_W-1:0] {
    INICIAL     = ST_INICIAL,
    PREPARA     = ST_PREPARA,
    ESPERA      = ST_ESPERA,
    REGISTRA    = ST_REGISTRA,
    COMPARA     = ST_COMPARA,
    PROX_JOGADA = ST_PROX_JOGADA,
    PROX_RODADA = ST_PROX_RODADA,
    FIM_ACERTO  = ST_FIM_ACERTO,
    FIM_ERRO    = ST_FIM_ERRO,
    FIM_TIMEOUT = ST_FIM_TIMEOUT
  } estado_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic reg0_q, reg1_q;

  // Two-flop sampler; pulse is "seen now, not seen last cycle".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg0_q <= 1'b0;
      reg1_q <= 1'b0;
    end else begin
      reg0_q <= sinal;
      reg1_q <= reg0_q;
    end
  end

  assign pulso = reg0_q & ~reg1_q;

endmodule

// File: rtl/jogo_sequencia_param_uc.sv
// Control unit: game FSM and Moore decode of datapath controls and result flags.
module unidade_controle_seq
  import jogo_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic            jogada,
  input  logic            timer_fim,
  input  logic            igual,
  input  logic            fim_rodada,
  input  logic            ultima_rodada,
  output logic            zera,
  output logic            conta_timer,
  output logic            registra,
  output logic            inc_jogada,
  output logic            inc_rodada,
  output logic            pronto,
  output logic            acertou,
  output logic            errou,
  output logic            timeout,
  output logic [ST_W-1:0] db_estado
);

  estado_t state_q, state_d;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Next state; a play pulse beats timer expiry, unused codes fall back to INICIAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:     if (iniciar) state_d = PREPARA;
      PREPARA:     state_d = ESPERA;
      ESPERA:      if (jogada)         state_d = REGISTRA;
                   else if (timer_fim) state_d = FIM_TIMEOUT;
      REGISTRA:    state_d = COMPARA;
      COMPARA:     if (!igual)             state_d = FIM_ERRO;
                   else if (!fim_rodada)   state_d = PROX_JOGADA;
                   else if (ultima_rodada) state_d = FIM_ACERTO;
                   else                    state_d = PROX_RODADA;
      PROX_JOGADA: state_d = ESPERA;
      PROX_RODADA: state_d = ESPERA;
      FIM_ACERTO:  if (iniciar) state_d = PREPARA;
      FIM_ERRO:    if (iniciar) state_d = PREPARA;
      FIM_TIMEOUT: if (iniciar) state_d = PREPARA;
      default:     state_d = INICIAL;
    endcase
  end

  // Moore output decode from the current state only.
  always_comb begin
    zera        = 1'b0;
    conta_timer = 1'b0;
    registra    = 1'b0;
    inc_jogada  = 1'b0;
    inc_rodada  = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      PREPARA:     zera        = 1'b1;
      ESPERA:      conta_timer = 1'b1;
      REGISTRA:    registra    = 1'b1;
      PROX_JOGADA: inc_jogada  = 1'b1;
      PROX_RODADA: inc_rodada  = 1'b1;
      FIM_ACERTO:  begin pronto = 1'b1; acertou = 1'b1; end
      FIM_ERRO:    begin pronto = 1'b1; errou   = 1'b1; end
      FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
      default:     ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: rtl/jogo_sequencia_param.sv
// Genius-style memory game top: datapath (counters, timer, play register,
// edge detector, comparator) around the control unit.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int N_CHAVES = 4,
  parameter int PROF     = 16,
  parameter int END_W    = 4,
  parameter int TIMEOUT  = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [END_W-1:0]    mem_endereco,
  input  logic [N_CHAVES-1:0] mem_dado,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [N_CHAVES-1:0] leds,
  output logic                db_tem_jogada,
  output logic [END_W-1:0]    db_contagem,
  output logic [END_W-1:0]    db_rodada,
  output logic [N_CHAVES-1:0] db_jogada,
  output logic [3:0]          db_estado
);

  localparam int TW = largura(TIMEOUT);
  localparam logic [TW-1:0]    TIMER_MAX  = TW'(TIMEOUT - 1);
  localparam logic [END_W-1:0] RODADA_MAX = END_W'(PROF - 1);

  logic [END_W-1:0]    contagem_q, contagem_d;
  logic [END_W-1:0]    rodada_q, rodada_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_CHAVES-1:0] jogada_q, jogada_d;

  logic zera, conta_timer, registra, inc_jogada, inc_rodada, pulso;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sinal (|chaves),
    .pulso (pulso)
  );

  unidade_controle_seq u_uc (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .jogada        (pulso),
    .timer_fim     (timer_q == TIMER_MAX),
    .igual         (jogada_q == mem_dado),
    .fim_rodada    (contagem_q == rodada_q),
    .ultima_rodada (rodada_q == RODADA_MAX),
    .zera          (zera),
    .conta_timer   (conta_timer),
    .registra      (registra),
    .inc_jogada    (inc_jogada),
    .inc_rodada    (inc_rodada),
    .pronto        (pronto),
    .acertou       (acertou),
    .errou         (errou),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  // Datapath next-state; only one control strobe is active per state.
  always_comb begin
    contagem_d = contagem_q;
    rodada_d   = rodada_q;
    timer_d    = timer_q;
    jogada_d   = jogada_q;
    if (zera) begin
      contagem_d = '0;
      rodada_d   = '0;
      timer_d    = '0;
      jogada_d   = '0;
    end
    if (conta_timer) timer_d  = timer_q + 1'b1;
    if (registra)    jogada_d = chaves;
    if (inc_jogada) begin
      contagem_d = contagem_q + 1'b1;
      timer_d    = '0;
    end
    if (inc_rodada) begin
      rodada_d   = rodada_q + 1'b1;
      contagem_d = '0;
      timer_d    = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_q <= '0;
      rodada_q   <= '0;
      timer_q    <= '0;
      jogada_q   <= '0;
    end else begin
      contagem_q <= contagem_d;
      rodada_q   <= rodada_d;
      timer_q    <= timer_d;
      jogada_q   <= jogada_d;
    end
  end

  assign mem_endereco  = contagem_q;
  assign leds          = chaves;
  assign db_tem_jogada = |chaves;
  assign db_contagem   = contagem_q;
  assign db_rodada     = rodada_q;
  assign db_jogada     = jogada_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: tables, corner-case sequences, random games vs. a game-rule model.
module tb_jogo_sequencia_param;
  localparam int NC = 4, PROF = 4, EW = 4, TO = 20;

  logic          clock = 1'b0, reset = 1'b0, iniciar = 1'b0;
  logic [NC-1:0] chaves = '0;
  logic [EW-1:0] mem_endereco;
  logic [NC-1:0] mem_dado = '0;
  logic          pronto, acertou, errou, timeout, db_tem_jogada;
  logic [NC-1:0] leds, db_jogada;
  logic [EW-1:0] db_contagem, db_rodada;
  logic [3:0]    db_estado;

  jogo_sequencia_param #(.N_CHAVES(NC), .PROF(PROF), .END_W(EW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .mem_endereco(mem_endereco), .mem_dado(mem_dado), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .leds(leds),
    .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem), .db_rodada(db_rodada),
    .db_jogada(db_jogada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory, one cycle latency.
  logic [NC-1:0] mem [PROF];
  always @(posedge clock) mem_dado <= mem[mem_endereco[1:0]];

  // Registered-play counter (cycles spent in state 3).
  int n_reg = 0;
  always @(negedge clock) if (db_estado == 4'd3) n_reg <= n_reg + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Wait (bounded) until the game is back in ESPERA or finished.
  task automatic settle(input string nm);
    for (int k = 0; k < 12; k++) begin
      if (db_estado == 4'd2 || pronto) break;
      @(negedge clock);
    end
    if (!(db_estado == 4'd2 || pronto)) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no settle, estado %0d, expected 2 or finished", nm, db_estado);
    end
  endtask

  task automatic start(input string nm);
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    settle(nm);
  endtask

  // Press v after d idle cycles in ESPERA, hold past REGISTRA, release.
  task automatic play(input logic [NC-1:0] v, input int d, input string nm);
    repeat (d) @(negedge clock);
    chaves = v;
    repeat (3) @(negedge clock);
    chaves = '0;
    settle(nm);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0; chaves = '0; iniciar = 1'b0;
    repeat (2) @(negedge clock); reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct { logic [NC-1:0] key; logic [NC-1:0] leds; logic tem; } led_t;
  typedef struct { logic [NC-1:0] key; int rod; int cont; int est; } jog_t;
  led_t tl[4];
  jog_t t1[10];

  initial begin
    int base, r, c, outc, act, d, steps;
    logic [NC-1:0] v;

    tl[0] = '{4'h0, 4'h0, 1'b0}; tl[1] = '{4'h5, 4'h5, 1'b1};
    tl[2] = '{4'h8, 4'h8, 1'b1}; tl[3] = '{4'hF, 4'hF, 1'b1};
    t1[0] = '{4'd1, 1, 0, 2}; t1[1] = '{4'd1, 1, 1, 2}; t1[2] = '{4'd2, 2, 0, 2};
    t1[3] = '{4'd1, 2, 1, 2}; t1[4] = '{4'd2, 2, 2, 2}; t1[5] = '{4'd4, 3, 0, 2};
    t1[6] = '{4'd1, 3, 1, 2}; t1[7] = '{4'd2, 3, 2, 2}; t1[8] = '{4'd4, 3, 3, 2};
    t1[9] = '{4'd8, 3, 3, 7};
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;

    // Reset state and combinational key mirrors while reset is held.
    repeat (3) @(negedge clock);
    chk("rst_estado", db_estado, 0);
    chk("rst_pronto", {pronto, acertou, errou, timeout}, 0);
    chk("rst_cnt", {db_rodada, db_contagem, db_jogada}, 0);
    for (int i = 0; i < 4; i++) begin
      chaves = tl[i].key; #1;
      chk("leds", leds, tl[i].leds);
      chk("tem_jogada", db_tem_jogada, tl[i].tem);
    end
    chaves = '0;
    @(negedge clock); reset = 1'b1;

    // 1: full correct game.
    start("t1_start");
    base = n_reg;
    for (int i = 0; i < 10; i++) begin
      play(t1[i].key, 1, "t1_play");
      chk("t1_rodada", db_rodada, t1[i].rod);
      chk("t1_contagem", db_contagem, t1[i].cont);
      chk("t1_estado", db_estado, t1[i].est);
    end
    chk("t1_acertou", {pronto, acertou, errou, timeout}, 4'b1100);
    chk("t1_nplays", n_reg - base, 10);

    // 2: wrong key in round 1.
    start("t2_start");
    play(4'd1, 0, "t2"); play(4'd1, 0, "t2"); play(4'd4, 0, "t2");
    chk("t2_flags", {pronto, acertou, errou, timeout}, 4'b1010);
    chk("t2_rodada", db_rodada, 1);
    chk("t2_contagem", db_contagem, 1);
    chk("t2_estado", db_estado, 8);

    // 3: timeout on the 21st cycle of ESPERA.
    start("t3_start");
    repeat (19) @(negedge clock);
    chk("t3_before", {db_estado, timeout}, {4'd2, 1'b0});
    @(negedge clock);
    chk("t3_flags", {pronto, acertou, errou, timeout}, 4'b1001);
    chk("t3_estado", db_estado, 9);

    // 4: pulse coincides with timer == TIMEOUT-1.
    start("t4_start");
    play(4'd1, 18, "t4");
    chk("t4_timeout", timeout, 0);
    chk("t4_state", {db_estado, db_rodada}, {4'd2, 4'd1});

    // 5: async reset while in COMPARA.
    start("t5_start");
    chaves = 4'd1;
    for (int k = 0; k < 10 && db_estado != 4'd4; k++) @(negedge clock);
    chk("t5_in_compara", db_estado, 4);
    reset = 1'b0; #1;
    chk("t5_estado", db_estado, 0);
    chk("t5_flags", {pronto, acertou, errou, timeout, db_rodada}, 0);
    chaves = '0;
    @(negedge clock); reset = 1'b1;
    start("t5_restart");
    chk("t5_restart", db_estado, 2);

    // 6: key held through iniciar gives no play until re-pressed.
    do_reset();
    chaves = 4'd1;
    @(negedge clock);
    start("t6_start");
    repeat (5) @(negedge clock);
    chk("t6_noplay", db_estado, 2);
    chaves = '0;
    repeat (2) @(negedge clock);
    chaves = 4'd1;
    @(negedge clock);
    @(negedge clock); chk("t6_registra", db_estado, 3);
    @(negedge clock); chk("t6_compara", db_estado, 4);
    chaves = '0;
    settle("t6");
    chk("t6_round", {db_estado, db_rodada, db_contagem}, {4'd2, 4'd1, 4'd0});

    // Random games against the game-rule model.
    do_reset();
    for (int g = 0; g < 25; g++) begin
      for (int i = 0; i < PROF; i++) mem[i] = 4'($urandom_range(1, 15));
      start("rnd_start");
      r = 0; c = 0; outc = 0; steps = 0;
      while (outc == 0 && steps < 20) begin
        steps++;
        act = $urandom_range(0, 11);
        if (act == 0) begin
          repeat (25) @(negedge clock);
          outc = 3;
        end else begin
          v = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : mem[c];
          d = $urandom_range(0, 12);
          play(v, d, "rnd_play");
          if (v != mem[c])      outc = 2;
          else if (c < r)       c++;
          else if (r == PROF-1) outc = 1;
          else begin r++; c = 0; end
          if (outc == 0) chk("rnd_pos", {pronto, db_rodada, db_contagem}, {1'b0, 4'(r), 4'(c)});
        end
      end
      chk("rnd_flags", {pronto, acertou, errou, timeout},
          {1'b1, outc == 1, outc == 2, outc == 3});
      chk("rnd_estado", db_estado, 6 + outc);
      chk("rnd_rodada", db_rodada, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule
